// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction sequencer: opcode encodings, the
// controller FSM state type and the ALU operation type, plus the decode helper
// that maps an opcode onto an ALU operation.
// Optional feature macro used by the consumers of this package: CTRL_FLAGS_EN.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [2:0] OP_LDX  = 3'b000;
    localparam logic [2:0] OP_LDY  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_DISP = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB
    } alu_op_t;

    // Loads pass the immediate straight through; everything that is not an
    // add or subtract uses PASS because its ALU result is never written.
    function automatic alu_op_t alu_op_of(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu
// Combinational add / subtract / pass unit. The result is one bit wider than
// the operands: bit DATA_W is the carry out of an add or the borrow of a
// subtract (set when a < b); the low DATA_W bits wrap modulo 2^DATA_W.
// Ports:
//   op   in   alu_op_t      operation select
//   a    in   DATA_W        first operand (passed through for ALU_PASS)
//   b    in   DATA_W        second operand
//   res  out  DATA_W+1      {carry/borrow, result}
// -----------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   res
);

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD: res = {1'b0, a} + {1'b0, b};
            ALU_SUB: res = {1'b0, a} - {1'b0, b};
            default: res = {1'b0, a};
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Instruction sequencer and datapath controller. Requests one instruction at a
// time from instruction memory, latches opcode/immediate, executes against the
// internal X/Y/Z registers and presents Z on the display port.
// Sequence per instruction: FETCH (handshake) -> EXEC (ALU into temp) -> WB.
// Optional feature: define CTRL_FLAGS_EN to add the carry/zero flag outputs.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   run          in   1 = keep fetching, 0 = stop after current instruction
//   instr_req    out  request to instruction memory, held until instr_valid
//   instr_valid  in   opcode/imm valid, sampled only while instr_req = 1
//   opcode       in   OP_W instruction opcode
//   imm          in   DATA_W immediate operand
//   disp         out  DATA_W last displayed Z value
//   disp_valid   out  one-cycle pulse when disp updates
//   busy         out  high in every state except IDLE
//   carry, zero  out  ALU flags (CTRL_FLAGS_EN only)
// -----------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] disp,
    output logic              disp_valid,
    output logic              busy
`ifdef CTRL_FLAGS_EN
    ,
    output logic              carry,
    output logic              zero
`endif
);

    state_t            state;
    logic [OP_W-1:0]   ir_op_p0;
    logic [DATA_W-1:0] ir_imm_p0;
    logic [DATA_W-1:0] alu_res_p1;
    logic [DATA_W-1:0] reg_x;
    logic [DATA_W-1:0] reg_y;
    logic [DATA_W-1:0] reg_z;

    logic [2:0]        op_dec;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W:0]   alu_res;

    assign op_dec = 3'(ir_op_p0);
    assign alu_op = alu_op_of(op_dec);
    // Loads route the immediate through the ALU so EXEC has a single temp path.
    assign alu_a  = (alu_op == ALU_PASS) ? ir_imm_p0 : reg_x;

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (reg_y),
        .res (alu_res)
    );

`ifdef CTRL_FLAGS_EN
    logic carry_p1;
`else
    logic unused_carry;
    assign unused_carry = alu_res[DATA_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            instr_req  <= 1'b0;
            busy       <= 1'b0;
            disp       <= '0;
            disp_valid <= 1'b0;
            ir_op_p0   <= '0;
            ir_imm_p0  <= '0;
            alu_res_p1 <= '0;
            reg_x      <= '0;
            reg_y      <= '0;
            reg_z      <= '0;
`ifdef CTRL_FLAGS_EN
            carry_p1   <= 1'b0;
            carry      <= 1'b0;
            zero       <= 1'b0;
`endif
        end else begin
            disp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state     <= ST_FETCH;
                        instr_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                // Fetch -> instruction register. A response arriving in the
                // same cycle run drops still completes the handshake.
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_op_p0  <= opcode;
                        ir_imm_p0 <= imm;
                        instr_req <= 1'b0;
                        state     <= ST_EXEC;
                    end else if (!run) begin
                        instr_req <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                // Instruction register -> ALU temp.
                ST_EXEC: begin
                    alu_res_p1 <= alu_res[DATA_W-1:0];
`ifdef CTRL_FLAGS_EN
                    carry_p1   <= alu_res[DATA_W];
`endif
                    state      <= ST_WB;
                end

                // ALU temp -> architectural registers / display.
                ST_WB: begin
                    case (op_dec)
                        OP_LDX: reg_x <= alu_res_p1;
                        OP_LDY: reg_y <= alu_res_p1;
                        OP_ADD, OP_SUB: begin
                            reg_z <= alu_res_p1;
`ifdef CTRL_FLAGS_EN
                            carry <= carry_p1;
                            zero  <= (alu_res_p1 == '0);
`endif
                        end
                        OP_CLR: begin
                            reg_x <= '0;
                            reg_y <= '0;
                            reg_z <= '0;
`ifdef CTRL_FLAGS_EN
                            carry <= 1'b0;
                            zero  <= 1'b0;
`endif
                        end
                        OP_DISP: begin
                            disp       <= reg_z;
                            disp_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (run) begin
                        state     <= ST_FETCH;
                        instr_req <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    instr_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Self-checking bench for cpu_control_fsm. A memory model answers instr_req
// from directed instruction sequences; a reference model of X/Y/Z and flags
// pushes the expected display value onto a scoreboard whenever a DISP is
// handed to the DUT, and a monitor pops and compares on every disp_valid.
// Build with +define+CTRL_FLAGS_EN to also check carry/zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              instr_req;
    logic              instr_valid;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] disp;
    logic              disp_valid;
    logic              busy;
`ifdef CTRL_FLAGS_EN
    logic              carry;
    logic              zero;
`endif

    cpu_control_fsm #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instr_req   (instr_req),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .imm         (imm),
        .disp        (disp),
        .disp_valid  (disp_valid),
        .busy        (busy)
`ifdef CTRL_FLAGS_EN
        ,
        .carry       (carry),
        .zero        (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              c;
        logic              z;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_dv_cyc = 0;
    logic prev_dv = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] mx, my, mz;
    logic              mc, mzf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = '0; my = '0; mz = '0; mc = 1'b0; mzf = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [DATA_W-1:0] im);
        logic [DATA_W:0] s;
        case (op)
            3'b000: mx = im;
            3'b001: my = im;
            3'b010: begin
                s = {1'b0, mx} + {1'b0, my};
                mz = s[DATA_W-1:0]; mc = s[DATA_W]; mzf = (mz == '0);
            end
            3'b011: begin
                mz = mx - my; mc = (mx < my); mzf = (mz == '0);
            end
            3'b100: begin
                mx = '0; my = '0; mz = '0; mc = 1'b0; mzf = 1'b0;
            end
            3'b101: sb_q.push_back('{d: mz, c: mc, z: mzf});
            default: ;
        endcase
    endtask

    // Memory model: entered and left on a falling edge. Waits (bounded) for a
    // request, stalls for the given number of cycles, then answers.
    task automatic feed(input logic [2:0] op, input logic [DATA_W-1:0] im, input int stall);
        int n;
        n = 0;
        while (!instr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_req) begin
            check("req_timeout", 16'd0, 16'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            instr_valid = 1'b0;
            @(negedge clk);
            check("req_held", 16'(instr_req), 16'd1);
        end
        instr_valid = 1'b1;
        opcode      = op;
        imm         = im;
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        model_apply(op, im);
        @(negedge clk);
        instr_valid = 1'b0;
        opcode      = 3'($urandom);
        imm         = 4'($urandom);
        check("req_fall", 16'(instr_req), 16'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_instr_req"}, 16'(instr_req), 16'd0);
        check({pfx, "_disp"}, 16'(disp), 16'd0);
        check({pfx, "_disp_valid"}, 16'(disp_valid), 16'd0);
        check({pfx, "_busy"}, 16'(busy), 16'd0);
`ifdef CTRL_FLAGS_EN
        check({pfx, "_carry"}, 16'(carry), 16'd0);
        check({pfx, "_zero"}, 16'(zero), 16'd0);
`endif
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && disp_valid) begin
            check("dv_single", 16'(prev_dv), 16'd0);
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 16'd1, 16'd0);
            end else begin
                e = sb_q.pop_front();
                check("disp", 16'(disp), 16'(e.d));
`ifdef CTRL_FLAGS_EN
                check("carry", 16'(carry), 16'(e.c));
                check("zero", 16'(zero), 16'(e.z));
`endif
            end
            last_dv_cyc = cyc;
        end
        prev_dv = disp_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n       = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b0;
        opcode      = '0;
        imm         = '0;
        model_reset();

        // Reset state
        wait_cycles(3);
        check_outputs_zero("rst");
        rst_n = 1'b1;
        wait_cycles(2);
        check("idle_busy", 16'(busy), 16'd0);
        check("idle_req", 16'(instr_req), 16'd0);

        // LDX 2, LDY 1, ADD, DISP with zero-wait memory
        run = 1'b1;
        @(negedge clk);
        check("start_req", 16'(instr_req), 16'd1);
        check("start_busy", 16'(busy), 16'd1);
        feed(3'b000, 4'd2, 0);
        t0 = last_acc_cyc;
        feed(3'b001, 4'd1, 0);
        feed(3'b010, 4'd0, 0);
        feed(3'b101, 4'd0, 0);
        check("tput", 16'(last_acc_cyc - t0), 16'd9);
        wait_cycles(3);
        check("disp_latency", 16'(last_dv_cyc - t0), 16'd11);

        // Wrap-around add: 0xF + 0x1
        feed(3'b000, 4'hF, 0);
        feed(3'b001, 4'h1, 0);
        feed(3'b010, 4'h0, 0);
        feed(3'b101, 4'h0, 0);

        // Wrap-around subtract: 0x2 - 0x5
        feed(3'b000, 4'h2, 0);
        feed(3'b001, 4'h5, 0);
        feed(3'b011, 4'h0, 0);
        feed(3'b101, 4'h0, 0);

        // Memory stalls: executes once, no extra writes
        feed(3'b000, 4'h3, 4);
        feed(3'b001, 4'h4, 2);
        feed(3'b010, 4'h0, 1);
        feed(3'b101, 4'h0, 0);

        // run dropped during EXEC of ADD
        feed(3'b000, 4'h6, 0);
        feed(3'b001, 4'h5, 0);
        feed(3'b010, 4'h0, 0);
        run = 1'b0;
        @(negedge clk);
        check("wb_busy", 16'(busy), 16'd1);
        @(negedge clk);
        check("stop_busy", 16'(busy), 16'd0);
        for (int i = 0; i < 3; i++) begin
            check("stop_no_req", 16'(instr_req), 16'd0);
            @(negedge clk);
        end

        // NOPs leave state alone; DISP shows the ADD result from before the stop
        run = 1'b1;
        @(negedge clk);
        feed(3'b110, 4'h9, 0);
        feed(3'b111, 4'hA, 0);
        feed(3'b101, 4'h0, 0);

        // run dropped in FETCH before instr_valid; valid in IDLE ignored
        begin
            int n;
            n = 0;
            while (!instr_req && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        run = 1'b0;
        @(negedge clk);
        check("fetch_drop_req", 16'(instr_req), 16'd0);
        check("fetch_drop_busy", 16'(busy), 16'd0);
        instr_valid = 1'b1;
        opcode      = 3'b000;
        imm         = 4'h9;
        wait_cycles(3);
        instr_valid = 1'b0;
        run = 1'b1;
        @(negedge clk);
        feed(3'b011, 4'h0, 0);
        feed(3'b101, 4'h0, 0);

        // CLR then DISP
        feed(3'b100, 4'h0, 0);
        feed(3'b101, 4'h0, 0);

        // Reset asserted during WB of LDX 7
        feed(3'b001, 4'h2, 0);
        feed(3'b010, 4'h0, 0);
        feed(3'b000, 4'h7, 0);
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check_outputs_zero("wb_rst");
        model_reset();
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        check("post_rst_busy", 16'(busy), 16'd0);
        check("post_rst_req", 16'(instr_req), 16'd0);
        run = 1'b1;
        @(negedge clk);
        feed(3'b010, 4'h0, 0);
        feed(3'b101, 4'h0, 0);
        feed(3'b001, 4'h3, 0);
        feed(3'b011, 4'h0, 0);
        feed(3'b101, 4'h0, 0);

        wait_cycles(4);
        check("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
